fifo_read_ctrl: RTL

//  Read-side controller of the async FIFO, single clock domain clk_r. Owns the read

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/fifo_skid_buf.sv | 53 +++++
 rtl/fifo_read_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Types and Gray-code helpers shared by the async FIFO read- and write-side controllers.
// Helpers work on a wide pointer; callers zero-extend their (A+1)-bit pointer and truncate the result.
package fifo_pkg;

    localparam int FIFO_DATA_SIZE_DEF = 3;
    localparam int FIFO_ADDR_SIZE_DEF = 2;
    localparam int PTR_MAX_W          = 16;

    typedef logic [FIFO_ADDR_SIZE_DEF:0] ptr_t;
    typedef logic [PTR_MAX_W-1:0]        ptr_wide_t;
    typedef logic [1:0]                  occ_t;

    function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Upper bits of a zero-extended Gray value are zero, so the prefix XOR stays exact.
    function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
        ptr_wide_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered skid buffer: the head register drives the stream, the tail absorbs
// the word already in flight from the RAM when the consumer stalls.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int D = FIFO_DATA_SIZE_DEF
) (
    input  logic         clk_r,
    input  logic         rst_r,
    input  logic         push,
    input  logic [D-1:0] push_data,
    input  logic         pop,
    output logic [D-1:0] head_data,
    output occ_t         occ
);

    logic [D-1:0] tail_data;

    // NOTE: the data registers are reset as well so the stream reads 0 after reset.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            occ       <= '0;
            head_data <= '0;
            tail_data <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head_data <= push_data;
                    else             tail_data <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd2) head_data <= tail_data;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever remains.
                    if (occ == 2'd2) begin
                        head_data <= tail_data;
                        tail_data <= push_data;
                    end else begin
                        head_data <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_r) disable iff (rst_r)
        !(push && !pop && occ == 2'd2));

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the async FIFO: read pointer, registered empty, RAM read issue and a
// valid/ready output stream. Define FIFO_RD_LEVEL_EN to add the registered rd_level output.
module fifo_read_ctrl
    import fifo_pkg::*;
#(
    parameter int FIFO_data_size = FIFO_DATA_SIZE_DEF,
    parameter int FIFO_addr_size = FIFO_ADDR_SIZE_DEF
) (
    input  logic                      clk_r,
    input  logic                      rst_r,
    input  logic [FIFO_addr_size:0]   w_ptr_gray_s,
    output logic [FIFO_addr_size:0]   r_ptr_gray,
    output logic                      r_en,
    output logic [FIFO_addr_size-1:0] r_addr,
    output logic                      empty,
    input  logic [FIFO_data_size-1:0] ram_data,
    output logic [FIFO_data_size-1:0] m_data,
    output logic                      m_valid,
    input  logic                      m_ready
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [FIFO_addr_size:0]   rd_level
`endif
);

    localparam int A = FIFO_addr_size;
    localparam int D = FIFO_data_size;

    typedef logic [A:0] rptr_t;

    rptr_t      r_ptr_bin;
    rptr_t      r_ptr_bin_next;
    rptr_t      r_ptr_gray_next;
    logic       inflight;
    logic       pop;
    occ_t       occ;
    logic [2:0] level;

    assign pop    = m_valid && m_ready;
    assign r_addr = r_ptr_bin[A-1:0];

    // Words the skid buffer will hold after this edge must leave room for a new read.
    // NOTE: every signal gets a default first so no latch can be inferred.
    always_comb begin
        level           = {1'b0, occ} + 3'(inflight) - 3'(pop);
        r_en            = !empty && (level < 3'd2);
        r_ptr_bin_next  = r_ptr_bin + rptr_t'(r_en);
        r_ptr_gray_next = rptr_t'(bin2gray(ptr_wide_t'(r_ptr_bin_next)));
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) begin
            r_ptr_bin  <= '0;
            r_ptr_gray <= '0;
            empty      <= 1'b1;
            inflight   <= 1'b0;
        end else begin
            r_ptr_bin  <= r_ptr_bin_next;
            r_ptr_gray <= r_ptr_gray_next;
            empty      <= (r_ptr_gray_next == w_ptr_gray_s);
            inflight   <= r_en;
        end
    end

    // The RAM drives valid data only in the cycle after a read, which is exactly when inflight is set.
    fifo_skid_buf #(
        .D(D)
    ) u_skid (
        .clk_r     (clk_r),
        .rst_r     (rst_r),
        .push      (inflight),
        .push_data (ram_data),
        .pop       (pop),
        .head_data (m_data),
        .occ       (occ)
    );

    assign m_valid = (occ != 2'd0);

`ifdef FIFO_RD_LEVEL_EN
    rptr_t w_ptr_bin_s;

    assign w_ptr_bin_s = rptr_t'(gray2bin(ptr_wide_t'(w_ptr_gray_s)));

    // Words still in the RAM, measured against the pointer value this edge commits.
    always_ff @(posedge clk_r or posedge rst_r) begin
        if (rst_r) rd_level <= '0;
        else       rd_level <= w_ptr_bin_s - r_ptr_bin_next;
    end
`endif

endmodule
